// File: rtl/ras_ckpt.sv
// Return address stack for the fetch-stage predictor with speculative push/pop
// and checkpoint repair. A circular array overwrites its oldest entry when a push arrives while it is full.
module ras_ckpt #(
   parameter  int DEPTH = 8,
   parameter  int AW    = 31,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = 2*PW+1+AW
) (
   input  logic          s_clk_i,
   input  logic          s_reset_i,
   input  logic          s_flush_i,
   input  logic          s_invalidate_i,
   input  logic          s_enable_i,
   input  logic          s_push_i,
   input  logic          s_pop_i,
   input  logic [AW-1:0] s_push_addr_i,
   input  logic          s_restore_i,
   input  logic [CW-1:0] s_restore_ckpt_i,
   output logic          s_poped_o,
   output logic [AW-1:0] s_pop_addr_o,
   output logic          s_empty_o,
   output logic          s_full_o,
   output logic [CW-1:0] s_ckpt_o,
   output logic          s_ovf_o
);

   typedef struct packed {
      logic [PW:0]   count;
      logic [PW-1:0] ptr;
      logic [AW-1:0] top;
   } ckpt_t;

   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr, ptr_nxt, wr_idx;
   logic [PW:0]   count, count_nxt;
   logic [AW-1:0] wr_data;
   logic          wr_en, ovf_nxt, empty, full;
   ckpt_t         rst_ckpt;

   assign rst_ckpt = ckpt_t'(s_restore_ckpt_i);
   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);

   assign s_empty_o    = empty;
   assign s_full_o     = full;
   assign s_pop_addr_o = mem[ptr];
   assign s_ckpt_o     = {count, ptr, mem[ptr]};
   assign s_poped_o    = s_pop_i & ~s_push_i & s_enable_i & ~s_flush_i
                       & ~s_restore_i & ~s_invalidate_i & ~empty;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      ptr_nxt   = ptr;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_idx    = ptr;
      wr_data   = s_push_addr_i;
      ovf_nxt   = 1'b0;
      if (s_invalidate_i) begin
         ptr_nxt   = '0;
         count_nxt = '0;
      end else if (s_restore_i) begin
         // The checkpoint carries the top entry because a later push may have overwritten that slot.
         ptr_nxt   = rst_ckpt.ptr;
         count_nxt = rst_ckpt.count;
         wr_en     = 1'b1;
         wr_idx    = rst_ckpt.ptr;
         wr_data   = rst_ckpt.top;
      end else if (!s_flush_i) begin
         if (s_push_i && s_pop_i && !empty) begin
            wr_en = 1'b1;
         end else if (s_push_i) begin
            ptr_nxt   = ptr + PTR_ONE;
            wr_idx    = ptr + PTR_ONE;
            wr_en     = 1'b1;
            count_nxt = full ? count : count + CNT_ONE;
            ovf_nxt   = full;
         end else if (s_pop_i && !empty) begin
            ptr_nxt   = ptr - PTR_ONE;
            count_nxt = count - CNT_ONE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples the same pre-edge values.
   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         ptr     <= '0;
         count   <= '0;
         s_ovf_o <= 1'b0;
      end else begin
         ptr     <= ptr_nxt;
         count   <= count_nxt;
         s_ovf_o <= ovf_nxt;
      end
   end

   // NOTE: the array is reset here so that s_pop_addr_o and s_ckpt_o read zero after reset.
   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (DEPTH=4). Expected values are queued when
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_ras_ckpt;
   localparam int DEPTH = 4;
   localparam int AW    = 31;
   localparam int PW    = 2;
   localparam int CW    = 2*PW+1+AW;

   logic          s_clk_i = 1'b0;
   logic          s_reset_i = 1'b0;
   logic          s_flush_i = 1'b0, s_invalidate_i = 1'b0, s_enable_i = 1'b0;
   logic          s_push_i = 1'b0, s_pop_i = 1'b0, s_restore_i = 1'b0;
   logic [AW-1:0] s_push_addr_i = '0;
   logic [CW-1:0] s_restore_ckpt_i = '0;
   logic          s_poped_o, s_empty_o, s_full_o, s_ovf_o;
   logic [AW-1:0] s_pop_addr_o;
   logic [CW-1:0] s_ckpt_o;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;
   exp_t sb[$];

   ras_ckpt #(.DEPTH(DEPTH), .AW(AW)) dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_flush_i(s_flush_i),
      .s_invalidate_i(s_invalidate_i), .s_enable_i(s_enable_i), .s_push_i(s_push_i),
      .s_pop_i(s_pop_i), .s_push_addr_i(s_push_addr_i), .s_restore_i(s_restore_i),
      .s_restore_ckpt_i(s_restore_ckpt_i), .s_poped_o(s_poped_o), .s_pop_addr_o(s_pop_addr_o),
      .s_empty_o(s_empty_o), .s_full_o(s_full_o), .s_ckpt_o(s_ckpt_o), .s_ovf_o(s_ovf_o)
   );

   always #5 s_clk_i = ~s_clk_i;

   always @(posedge s_clk_i) begin
      if (s_restore_i)
         assert (s_restore_ckpt_i[CW-1 -: PW+1] <= (PW+1)'(DEPTH))
            else $error("illegal checkpoint count %0d", s_restore_ckpt_i[CW-1 -: PW+1]);
   end

   wire [PW:0]   cnt    = s_ckpt_o[CW-1 -: PW+1];
   wire [PW-1:0] ptr_ob = s_ckpt_o[AW +: PW];

   task automatic expect_val(input string tag, input logic [63:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input string tag, input logic [63:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val && e.tag == tag) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (queued tag %s)", tag, obs, e.val, e.tag);
         end
      end
   endtask

   task automatic cyc();
      @(posedge s_clk_i);
      #1;
   endtask

   task automatic idle();
      s_flush_i = 0; s_invalidate_i = 0; s_push_i = 0; s_pop_i = 0; s_restore_i = 0;
   endtask

   task automatic push(input logic [AW-1:0] a);
      idle(); s_push_i = 1; s_push_addr_i = a; cyc(); idle();
   endtask

   task automatic invalidate();
      idle(); s_invalidate_i = 1; cyc(); idle();
   endtask

   // Pop one entry with prediction enabled; checks the predicted address and valid.
   task automatic pop_check(input string tag, input logic [AW-1:0] a, input logic v);
      idle(); s_enable_i = 1; s_pop_i = 1; #1;
      expect_val({tag, "_poped"}, 64'(v));
      check({tag, "_poped"}, 64'(s_poped_o));
      expect_val({tag, "_addr"}, 64'(a));
      check({tag, "_addr"}, 64'(s_pop_addr_o));
      cyc(); idle();
   endtask

   logic [CW-1:0] saved;

   initial begin
      // Reset values
      #1 s_reset_i = 1;
      #2;
      expect_val("rst_empty", 1);  check("rst_empty", 64'(s_empty_o));
      expect_val("rst_full", 0);   check("rst_full", 64'(s_full_o));
      expect_val("rst_poped", 0);  check("rst_poped", 64'(s_poped_o));
      expect_val("rst_ckpt", 0);   check("rst_ckpt", 64'(s_ckpt_o));
      expect_val("rst_ovf", 0);    check("rst_ovf", 64'(s_ovf_o));
      cyc();
      s_reset_i = 0;

      // Basic push then pop
      push(31'h100); push(31'h200); push(31'h300);
      expect_val("p3_top", 31'h300);  check("p3_top", 64'(s_pop_addr_o));
      expect_val("p3_cnt", 3);        check("p3_cnt", 64'(cnt));
      expect_val("p3_empty", 0);      check("p3_empty", 64'(s_empty_o));
      pop_check("pop1", 31'h300, 1);
      expect_val("pop1_next", 31'h200); check("pop1_next", 64'(s_pop_addr_o));

      // Overflow and drain
      invalidate();
      expect_val("inv_empty", 1);  check("inv_empty", 64'(s_empty_o));
      push(31'h1); push(31'h2); push(31'h3);
      expect_val("f3_full", 0);    check("f3_full", 64'(s_full_o));
      push(31'h4);
      expect_val("f4_full", 1);    check("f4_full", 64'(s_full_o));
      expect_val("f4_ovf", 0);     check("f4_ovf", 64'(s_ovf_o));
      push(31'h5);
      expect_val("f5_ovf", 1);     check("f5_ovf", 64'(s_ovf_o));
      expect_val("f5_cnt", 4);     check("f5_cnt", 64'(cnt));
      pop_check("drain5", 31'h5, 1);
      expect_val("ovf_clear", 0);  check("ovf_clear", 64'(s_ovf_o));
      pop_check("drain4", 31'h4, 1);
      pop_check("drain3", 31'h3, 1);
      pop_check("drain2", 31'h2, 1);
      expect_val("drain_empty", 1); check("drain_empty", 64'(s_empty_o));
      expect_val("drain_ptr", 1);   check("drain_ptr", 64'(ptr_ob));
      idle(); s_enable_i = 1; s_pop_i = 1; #1;
      expect_val("under_poped", 0); check("under_poped", 64'(s_poped_o));
      cyc(); idle();
      expect_val("under_ptr", 1);   check("under_ptr", 64'(ptr_ob));
      expect_val("under_cnt", 0);   check("under_cnt", 64'(cnt));

      // Simultaneous push and pop replaces the top
      invalidate();
      push(31'hA); push(31'hB);
      idle(); s_enable_i = 1; s_push_i = 1; s_pop_i = 1; s_push_addr_i = 31'hC; #1;
      expect_val("pp_poped", 0);   check("pp_poped", 64'(s_poped_o));
      cyc(); idle();
      expect_val("pp_top", 31'hC); check("pp_top", 64'(s_pop_addr_o));
      expect_val("pp_cnt", 2);     check("pp_cnt", 64'(cnt));
      pop_check("pp_pop", 31'hC, 1);
      expect_val("pp_next", 31'hA); check("pp_next", 64'(s_pop_addr_o));

      // Checkpoint and restore
      invalidate();
      push(31'hA); push(31'hB);
      saved = s_ckpt_o;
      expect_val("ck_snap", {28'd0, 3'd2, 2'd2, 31'hB}); check("ck_snap", 64'(saved));
      pop_check("ck_pop", 31'hB, 1);
      push(31'hD); push(31'hE);
      expect_val("ck_spec_top", 31'hE); check("ck_spec_top", 64'(s_pop_addr_o));
      idle(); s_restore_i = 1; s_restore_ckpt_i = saved; s_push_i = 1; s_push_addr_i = 31'h55;
      cyc(); idle();
      expect_val("rs_cnt", 2);     check("rs_cnt", 64'(cnt));
      expect_val("rs_top", 31'hB); check("rs_top", 64'(s_pop_addr_o));
      pop_check("rs_pop", 31'hB, 1);
      expect_val("rs_next", 31'hA); check("rs_next", 64'(s_pop_addr_o));

      // Priority: invalidate beats restore/push/flush; flush suppresses push
      idle(); s_restore_i = 1; s_restore_ckpt_i = saved; s_invalidate_i = 1;
      s_push_i = 1; s_flush_i = 1; s_push_addr_i = 31'h77;
      cyc(); idle();
      expect_val("pri_cnt", 0);    check("pri_cnt", 64'(cnt));
      expect_val("pri_empty", 1);  check("pri_empty", 64'(s_empty_o));
      push(31'h50);
      idle(); s_flush_i = 1; s_push_i = 1; s_push_addr_i = 31'h99;
      cyc(); idle();
      expect_val("fl_cnt", 1);     check("fl_cnt", 64'(cnt));
      expect_val("fl_top", 31'h50); check("fl_top", 64'(s_pop_addr_o));

      // Asynchronous reset between edges
      push(31'h60); push(31'h70);
      expect_val("ar_pre_cnt", 3); check("ar_pre_cnt", 64'(cnt));
      #3 s_reset_i = 1;
      #1;
      expect_val("ar_cnt", 0);     check("ar_cnt", 64'(cnt));
      expect_val("ar_empty", 1);   check("ar_empty", 64'(s_empty_o));
      expect_val("ar_top", 0);     check("ar_top", 64'(s_pop_addr_o));
      s_push_i = 1; s_push_addr_i = 31'h123;
      cyc();
      expect_val("ar_hold_cnt", 0); check("ar_hold_cnt", 64'(cnt));
      s_reset_i = 0; s_push_addr_i = 31'h40;
      cyc(); idle();
      expect_val("ar_post_cnt", 1);    check("ar_post_cnt", 64'(cnt));
      expect_val("ar_post_top", 31'h40); check("ar_post_top", 64'(s_pop_addr_o));

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised return address stack for the fetch-stage predictor, with speculative push/pop and checkpoint-based repair.
- The front-end decoder drives push/pop requests and attaches the emitted checkpoint to each predicted control-transfer instruction.
- On a resolved misprediction, the execute stage returns that checkpoint, restoring the stack pointer, occupancy and the possibly-overwritten top entry.
- Storage is an internal circular register array; the oldest entry is overwritten on overflow.

Parameters:
- DEPTH, 8, number of entries; power of two, >=2.
- AW, 31, width of a stored return address (halfword-granular, bit 0 = RVC offset).
- PW, $clog2(DEPTH), derived pointer width; not overridable.
- CW, 2*PW+1+AW, derived checkpoint width; not overridable.

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  asynchronous active-high reset
- s_flush_i  in  1  suppress push/pop this cycle
- s_invalidate_i  in  1  drop all entries (synchronous)
- s_enable_i  in  1  allow pop prediction
- s_push_i  in  1  push request
- s_pop_i  in  1  pop request
- s_push_addr_i  in  AW  address to push
- s_restore_i  in  1  restore from checkpoint
- s_restore_ckpt_i  in  CW  checkpoint to restore, layout {count[PW:0], ptr[PW-1:0], top[AW-1:0]}
- s_poped_o  out  1  prediction valid this cycle
- s_pop_addr_o  out  AW  current top-of-stack entry
- s_empty_o  out  1  count==0
- s_full_o  out  1  count==DEPTH
- s_ckpt_o  out  CW  snapshot of the current state before this cycle's operation
- s_ovf_o  out  1  registered one-cycle pulse, set after a push into a full stack

Behaviour:
State:
- ptr[PW-1:0] indexes the top entry.
- count[PW:0] ranges 0..DEPTH.
- mem[DEPTH][AW].

Reset (async, s_reset_i=1):
- ptr=0, count=0, all mem=0, s_ovf_o=0.
- Outputs in reset: s_empty_o=1, s_full_o=0, s_poped_o=0, s_pop_addr_o=0, s_ckpt_o=0.

Outputs (combinational from current state):
- s_pop_addr_o = mem[ptr].
- s_ckpt_o = {count, ptr, mem[ptr]}.
- s_poped_o = s_pop_i & ~s_push_i & s_enable_i & ~s_flush_i & ~s_restore_i & ~s_invalidate_i & (count!=0).

Per-cycle update, in priority order (highest first):
1. s_invalidate_i: ptr=0, count=0. Mem is not cleared.
2. s_restore_i:
   - ptr = ckpt.ptr.
   - count = ckpt.count.
   - mem[ckpt.ptr] = ckpt.top.
   - Push/pop/flush are ignored this cycle.
3. s_flush_i: no state change.
4. Push only:
   - ptr = ptr+1 (mod DEPTH).
   - mem[ptr+1] = s_push_addr_i.
   - count = min(count+1, DEPTH).
   - If count==DEPTH before the push, the oldest entry is overwritten and s_ovf_o=1 next cycle.
5. Pop only:
   - If count!=0: ptr = ptr-1 (mod DEPTH), count = count-1.
   - If count==0: no change (underflow ignored, no prediction).
6. Push and pop together (coroutine jalr):
   - If count!=0: mem[ptr] = s_push_addr_i; ptr and count unchanged.
   - If count==0: behaves as push only.
   - s_poped_o=0.

Other rules:
- s_enable_i gates only s_poped_o; pops update state regardless of s_enable_i.
- s_ovf_o is 0 in every cycle not directly following an overflowing push.
- ckpt.count > DEPTH is illegal input; behaviour undefined. Assertion required in the bench.
- No internal latency: pushed data is visible on s_pop_addr_o in the next cycle.
- A reset asserted mid-operation discards any pending update.

Test Plan:
(all with DEPTH=4, AW=31)
- Reset, then push 0x100, 0x200, 0x300 over 3 cycles -> s_pop_addr_o=0x300, count=3, s_empty_o=0. Then pop with enable=1 -> s_poped_o=1 that cycle, s_pop_addr_o=0x200 next cycle.
- Push 0x1..0x5 (5 pushes) -> s_full_o=1 after the 4th push, s_ovf_o pulses 1 cycle after the 5th push. Then 4 pops return 0x5, 0x4, 0x3, 0x2 and s_empty_o=1. A 5th pop gives s_poped_o=0 and no pointer move.
- Stack {0xA, 0xB}, push=pop=1 with addr 0xC -> top=0xC, count stays 2, s_poped_o=0. Next pop exposes 0xA.
- Stack {0xA, 0xB}:
  - Capture s_ckpt_o (count=2, top=0xB).
  - Pop, then push 0xD (0xB slot overwritten), then push 0xE.
  - Restore with the captured checkpoint -> count=2, s_pop_addr_o=0xB, next pop yields 0xA.
- Restore, invalidate, push and flush all asserted together -> invalidate wins: count=0, s_empty_o=1. Flush+push alone -> no change.
- Assert s_reset_i asynchronously between clock edges with count=3 -> outputs go to reset values immediately with no clock edge; after release, a push of 0x40 gives count=1 and top=0x40.
